core_dcache_axi_read_master: RTL and testbench
==============================================

# core_dcache_axi_read_master

Converts the data cache's single-request block-fill interface (request, address, done, 256-bit block) into one AXI4 read burst of four 64-bit beats. Assembles the beats into a cache line and returns it with a one-cycle done pulse. Sits directly between the data cache controller/memory pair and the AXI interconnect read channels. Read-only; the write path is handled elsewhere.

## Interface
Parameters:
- ADDR_WIDTH, 64, byte address width.
- AXI_DATA_WIDTH, 64, AXI RDATA width; fixed at 64 in this revision.
- BLOCK_WIDTH, 256, cache line width; BLOCK_WIDTH/AXI_DATA_WIDTH = 4 beats.
- ID_WIDTH, 4, AXI ID width.
- ARID_VALUE, 0, constant driven on ARID.

Ports (clock: one clock; reset: asynchronous, active-low):
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_mem_read_req  in  1  fill request; level, held until done.
- i_mem_read_address  in  ADDR_WIDTH  miss address.
- o_mem_read_done  out  1  one-cycle pulse; block valid.
- o_block_to_cache  out  BLOCK_WIDTH  assembled line; word k = bytes 8k..8k+7 of the line.
- o_read_error  out  1  pulse with done if any beat had an error.
- o_arid  out  ID_WIDTH  = ARID_VALUE.
- o_araddr  out  ADDR_WIDTH  burst start address.
- o_arlen  out  8  = 3.
- o_arsize  out  3  = 3'b011.
- o_arburst  out  2  INCR or WRAP (see Configuration).
- o_arvalid  out  1.
- i_arready  in  1.
- i_rdata  in  AXI_DATA_WIDTH.
- i_rresp  in  2.
- i_rlast  in  1.
- i_rvalid  in  1.
- o_rready  out  1.

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: when i_mem_read_req=1, latch the address, clear the beat counter and error flag, and go to ADDR.
- ADDR: o_arvalid=1 with o_araddr stable; when i_arready=1, go to DATA.
- DATA: o_rready=1. On each handshake (i_rvalid & o_rready), write i_rdata into line word (start_word + beat) mod 4 and increment the 2-bit beat counter.
  - Error flag sets if i_rresp != 2'b00.
  - Error flag also sets on an i_rlast mismatch: i_rlast must be 1 exactly on beat 3.
  - Completion is count-based. On beat 3, go to DONE regardless of i_rlast.
- DONE: o_mem_read_done=1 and o_read_error=flag for this cycle only, then return to IDLE.
  - DONE costs one cycle, which gives the controller time to drop its request.
  - i_mem_read_req is ignored while in DONE.
- o_block_to_cache is a register. It updates only on beat writes and holds its value until the next burst's first beat.
- Outputs on reset: o_arvalid=0, o_rready=0, o_mem_read_done=0, o_read_error=0, o_araddr=0, o_block_to_cache=0, state=IDLE.
- Reset mid-burst aborts immediately; no done is issued. The interconnect is reset by the same i_rst_n.
- A request that drops in ADDR or DATA has no effect: the burst completes and done still pulses.

## Timing
- Request high at edge N (IDLE) gives o_arvalid=1 from N+1.
- o_arvalid holds, with all AR fields stable, until the i_arready edge. It is deasserted the next cycle.
- o_rready is asserted from the cycle after AR acceptance.
- Back-to-back beats are accepted every cycle.
- Minimum latency, request to done: 1 (ADDR) + 4 beats + 1 (DONE) = 6 cycles with zero-wait slave.
- Earliest next request sample: the cycle after DONE.
- AR and R never overlap; at most one burst is outstanding.

## Configuration
- DCACHE_AXI_CRITICAL_WORD_FIRST_EN defined:
  - o_araddr = address with bits [2:0] cleared.
  - o_arburst = WRAP (2'b10).
  - start_word = address[4:3]; beats fill words start_word, start_word+1, ... mod 4.
- Undefined:
  - o_araddr = address with bits [4:0] cleared.
  - o_arburst = INCR (2'b01).
  - start_word = 0.
- Done timing is unchanged in both cases; the critical word is not forwarded early.

## Structure
- Package core_axi_pkg holds:
  - AXI_BURST_INCR / AXI_BURST_WRAP;
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - AXI_SIZE_8B;
  - the FSM state enum typedef (rd_state_t);
  - BEATS_PER_BLOCK = 4.
- One sub-module, core_axi_beat_assembler, owns the line register, beat counter and word-placement logic. The FSM stays in the top module.

## Test plan
- Request 0x0000_1238, zero-wait slave, beats 0xA0..0xA3 -> o_araddr=0x1220, o_arlen=3. Done 6 cycles after request; block words {A3,A2,A1,A0} with word0=A0; o_read_error=0.
- i_arready held low 5 cycles -> o_arvalid stays 1 with o_araddr stable. Done at 11 cycles.
- i_rvalid toggling 1/0 across the beats -> only handshaked beats are stored; done is issued after the 4th beat.
- Beat 2 returns i_rresp=SLVERR -> burst completes; done and o_read_error pulse together.
- Assert i_rst_n=0 after beat 1 -> o_arvalid/o_rready/done go to 0 asynchronously. A fresh request after release completes normally.
- With DCACHE_AXI_CRITICAL_WORD_FIRST_EN, address 0x1230 -> o_araddr=0x1230, o_arburst=WRAP. Beats B0..B3 land in words 2,3,0,1.

Source files
------------

// File: rtl/core_axi_pkg.sv
// Shared AXI read-master constants, FSM state type and burst geometry.
package core_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_SIZE_8B     = 3'b011;
    localparam logic [7:0] AXI_LEN_4BEAT   = 8'd3;

    localparam int unsigned BEATS_PER_BLOCK = 4;
    localparam int unsigned BEAT_IDX_W      = $clog2(BEATS_PER_BLOCK);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA,
        RD_DONE
    } rd_state_t;

endpackage

// File: rtl/core_dcache_axi_read_master_if.sv
// AXI4 read address/data channels between the dcache read master and the
// interconnect.
//   master: drives AR payload/arvalid and rready
//   slave : drives arready and the R payload/rvalid
interface core_dcache_axi_read_master_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4
) ();
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/core_axi_beat_assembler.sv
// Places accepted R beats into the cache-line register.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clear        : start of a burst, zeroes the beat counter
//   i_start_word   : line word receiving beat 0 (wraps mod 4)
//   i_beat_valid   : R handshake this cycle
//   i_beat_data    : R payload
//   o_beat_cnt     : beats accepted so far in this burst (mod 4)
//   o_line         : assembled line; untouched words keep their old value
module core_axi_beat_assembler
    import core_axi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned BLOCK_WIDTH = 256
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clear,
    input  logic [BEAT_IDX_W-1:0]  i_start_word,
    input  logic                   i_beat_valid,
    input  logic [DATA_WIDTH-1:0]  i_beat_data,
    output logic [BEAT_IDX_W-1:0]  o_beat_cnt,
    output logic [BLOCK_WIDTH-1:0] o_line
);
    logic [BEAT_IDX_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [BLOCK_WIDTH-1:0] line_q, line_d;
    logic [BEAT_IDX_W-1:0]  word_idx;

    // Counter and placement; the 2-bit sum wraps for critical-word-first fills.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        line_d     = line_q;
        word_idx   = i_start_word + beat_cnt_q;
        if (i_clear) begin
            beat_cnt_d = '0;
        end else if (i_beat_valid) begin
            beat_cnt_d = beat_cnt_q + BEAT_IDX_W'(1);
            line_d[int'(word_idx)*DATA_WIDTH +: DATA_WIDTH] = i_beat_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat_cnt_q <= '0;
            line_q     <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            line_q     <= line_d;
        end
    end

    assign o_beat_cnt = beat_cnt_q;
    assign o_line     = line_q;
endmodule

// File: rtl/core_dcache_axi_read_master.sv
// Turns a dcache block-fill request into one 4-beat AXI4 read burst and
// returns the assembled line with a one-cycle done pulse.
//   i_clk, i_rst_n       : clock, async active-low reset
//   i_mem_read_req       : fill request (level)
//   i_mem_read_address   : miss byte address
//   o_mem_read_done      : one-cycle pulse, o_block_to_cache valid
//   o_block_to_cache     : assembled line, word k = bytes 8k..8k+7
//   o_read_error         : pulses with done if any beat errored
//   axi                  : AXI AR/R channels (master modport)
// Optional build macro DCACHE_AXI_CRITICAL_WORD_FIRST_EN: WRAP burst starting
// at the missed 8-byte word instead of an aligned INCR burst.
module core_dcache_axi_read_master
    import core_axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned BLOCK_WIDTH    = 256,
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned ARID_VALUE     = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_mem_read_req,
    input  logic [ADDR_WIDTH-1:0]  i_mem_read_address,
    output logic                   o_mem_read_done,
    output logic [BLOCK_WIDTH-1:0] o_block_to_cache,
    output logic                   o_read_error,
    core_dcache_axi_read_master_if.master axi
);
    rd_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [BEAT_IDX_W-1:0] start_word_q, start_word_d;
    logic                  err_flag_q, err_flag_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  done_q, done_d;
    logic                  read_error_q, read_error_d;
    logic                  burst_start;
    logic                  beat_fire;
    logic [BEAT_IDX_W-1:0] beat_cnt;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^i_mem_read_address[4:0];
    assign beat_fire        = axi.rvalid & rready_q;

    // Next state, burst bookkeeping and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        start_word_d = start_word_q;
        err_flag_d   = err_flag_q;
        burst_start  = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (i_mem_read_req) begin
`ifdef DCACHE_AXI_CRITICAL_WORD_FIRST_EN
                    araddr_d     = {i_mem_read_address[ADDR_WIDTH-1:3], 3'b000};
                    start_word_d = i_mem_read_address[4:3];
`else
                    araddr_d     = {i_mem_read_address[ADDR_WIDTH-1:5], 5'b00000};
                    start_word_d = '0;
`endif
                    err_flag_d   = 1'b0;
                    burst_start  = 1'b1;
                    state_d      = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (axi.arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (beat_fire) begin
                    if (axi.rresp != AXI_RESP_OKAY) begin
                        err_flag_d = 1'b1;
                    end
                    // rlast is only checked; completion is by beat count.
                    if (axi.rlast != (beat_cnt == BEAT_IDX_W'(BEATS_PER_BLOCK - 1))) begin
                        err_flag_d = 1'b1;
                    end
                    if (beat_cnt == BEAT_IDX_W'(BEATS_PER_BLOCK - 1)) begin
                        state_d = RD_DONE;
                    end
                end
            end
            RD_DONE: begin
                state_d = RD_IDLE;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
        arvalid_d    = (state_d == RD_ADDR);
        rready_d     = (state_d == RD_DATA);
        done_d       = (state_d == RD_DONE);
        read_error_d = (state_d == RD_DONE) & err_flag_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= RD_IDLE;
            araddr_q     <= '0;
            start_word_q <= '0;
            err_flag_q   <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            done_q       <= 1'b0;
            read_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            start_word_q <= start_word_d;
            err_flag_q   <= err_flag_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            done_q       <= done_d;
            read_error_q <= read_error_d;
        end
    end

    core_axi_beat_assembler #(
        .DATA_WIDTH  (AXI_DATA_WIDTH),
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) u_beat_assembler (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (burst_start),
        .i_start_word (start_word_q),
        .i_beat_valid (beat_fire),
        .i_beat_data  (axi.rdata),
        .o_beat_cnt   (beat_cnt),
        .o_line       (o_block_to_cache)
    );

    assign axi.arid    = ID_WIDTH'(ARID_VALUE);
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = AXI_LEN_4BEAT;
    assign axi.arsize  = AXI_SIZE_8B;
`ifdef DCACHE_AXI_CRITICAL_WORD_FIRST_EN
    assign axi.arburst = AXI_BURST_WRAP;
`else
    assign axi.arburst = AXI_BURST_INCR;
`endif
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign o_mem_read_done = done_q;
    assign o_read_error    = read_error_q;
endmodule

// File: tb/tb_core_dcache_axi_read_master.sv
// Scoreboard bench for core_dcache_axi_read_master: bursts push expected AR
// and line/done results; a negedge monitor compares whatever the DUT presents.
module tb_core_dcache_axi_read_master;
    import core_axi_pkg::*;

    logic           clk;
    logic           rst_n;
    logic           req;
    logic [63:0]    addr;
    logic           done;
    logic [255:0]   block;
    logic           rd_err;
    int             cyc;
    int             tests;
    int             fails;

    typedef struct {
        logic [255:0] blk;
        logic         err;
        int           req_cyc;
        int           lat;
    } done_exp_t;

    logic [63:0] ar_q[$];
    done_exp_t   done_q[$];
    logic        ar_active;

`ifdef DCACHE_AXI_CRITICAL_WORD_FIRST_EN
    localparam logic [1:0] EXP_BURST = 2'b10;
`else
    localparam logic [1:0] EXP_BURST = 2'b01;
`endif

    core_dcache_axi_read_master_if #(
        .ADDR_WIDTH (64),
        .DATA_WIDTH (64),
        .ID_WIDTH   (4)
    ) axi_if ();

    core_dcache_axi_read_master #(
        .ADDR_WIDTH     (64),
        .AXI_DATA_WIDTH (64),
        .BLOCK_WIDTH    (256),
        .ID_WIDTH       (4),
        .ARID_VALUE     (0)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_mem_read_req     (req),
        .i_mem_read_address (addr),
        .o_mem_read_done    (done),
        .o_block_to_cache   (block),
        .o_read_error       (rd_err),
        .axi                (axi_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: AR fields while arvalid is up, line/error on every done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (axi_if.arvalid) begin
                if (ar_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL ar_unexpected: got arvalid=1 araddr=%h expected no request", axi_if.araddr);
                end else begin
                    check("araddr", 256'(axi_if.araddr), 256'(ar_q[0]));
                    check("arlen", 256'(axi_if.arlen), 256'(8'd3));
                    check("arsize", 256'(axi_if.arsize), 256'(3'b011));
                    check("arburst", 256'(axi_if.arburst), 256'(EXP_BURST));
                    check("arid", 256'(axi_if.arid), 256'(4'd0));
                    check("rready_during_ar", 256'(axi_if.rready), 256'(1'b0));
                end
                ar_active = 1'b1;
            end else if (ar_active) begin
                if (ar_q.size() > 0) ar_q.delete(0);
                ar_active = 1'b0;
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL done_unexpected: got done=1 expected no done");
                end else begin
                    check("block", block, done_q[0].blk);
                    check("read_error", 256'(rd_err), 256'(done_q[0].err));
                    check("latency", 256'(cyc - done_q[0].req_cyc), 256'(done_q[0].lat));
                    done_q.delete(0);
                end
            end else if (rd_err) begin
                tests++;
                fails++;
                $display("FAIL error_without_done: got read_error=1 expected 0");
            end
        end else begin
            ar_active = 1'b0;
        end
    end

    // One fill request plus the slave side of its burst.
    task automatic run_burst(
        input logic [63:0]  a,
        input int           ar_wait,
        input logic [3:0]   gap_mask,
        input int           err_beat,
        input int           rlast_beat,
        input logic [7:0]   dbase,
        input logic [63:0]  exp_araddr,
        input logic [255:0] exp_blk,
        input logic         exp_err,
        input int           exp_lat,
        input bit           drop_early,
        input int           abort_after
    );
        done_exp_t e;
        bit        seen;
        @(posedge clk);
        #1;
        req  = 1'b1;
        addr = a;
        ar_q.push_back(exp_araddr);
        if (abort_after < 0) begin
            e.blk     = exp_blk;
            e.err     = exp_err;
            e.req_cyc = cyc;
            e.lat     = exp_lat;
            done_q.push_back(e);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (axi_if.arvalid) begin
                seen = 1'b1;
                break;
            end
        end
        check("arvalid_seen", 256'(seen), 256'(1'b1));
        repeat (ar_wait) @(negedge clk);
        axi_if.arready = 1'b1;
        @(posedge clk);
        #1;
        axi_if.arready = 1'b0;
        if (drop_early) req = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (gap_mask[b]) begin
                axi_if.rvalid = 1'b0;
                axi_if.rdata  = 64'hDEAD_BEEF_0BAD_F00D;
                @(posedge clk);
                #1;
            end
            axi_if.rvalid = 1'b1;
            axi_if.rdata  = 64'(dbase) + 64'(b);
            axi_if.rresp  = (b == err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            axi_if.rlast  = (b == rlast_beat);
            @(posedge clk);
            #1;
            if (b == abort_after) begin
                check("rready_before_reset", 256'(axi_if.rready), 256'(1'b1));
                rst_n = 1'b0;
                #1;
                check("reset_arvalid", 256'(axi_if.arvalid), 256'(1'b0));
                check("reset_rready", 256'(axi_if.rready), 256'(1'b0));
                check("reset_done", 256'(done), 256'(1'b0));
                check("reset_block", block, 256'(0));
                check("reset_araddr", 256'(axi_if.araddr), 256'(0));
                axi_if.rvalid = 1'b0;
                axi_if.rlast  = 1'b0;
                req           = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        axi_if.rvalid = 1'b0;
        axi_if.rlast  = 1'b0;
        axi_if.rresp  = AXI_RESP_OKAY;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 256'(seen), 256'(1'b1));
        req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] last_blk;
        tests          = 0;
        fails          = 0;
        ar_active      = 1'b0;
        rst_n          = 1'b0;
        req            = 1'b0;
        addr           = '0;
        axi_if.arready = 1'b0;
        axi_if.rvalid  = 1'b0;
        axi_if.rdata   = '0;
        axi_if.rresp   = 2'b00;
        axi_if.rlast   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_arvalid", 256'(axi_if.arvalid), 256'(1'b0));
        check("rst_rready", 256'(axi_if.rready), 256'(1'b0));
        check("rst_done", 256'(done), 256'(1'b0));
        check("rst_error", 256'(rd_err), 256'(1'b0));
        check("rst_araddr", 256'(axi_if.araddr), 256'(0));
        check("rst_block", block, 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

`ifdef DCACHE_AXI_CRITICAL_WORD_FIRST_EN
        // Zero-wait fill, start word 3.
        run_burst(64'h1238, 0, 4'b0000, -1, 3, 8'hA0, 64'h1238,
                  {64'hA0, 64'hA3, 64'hA2, 64'hA1}, 1'b0, 6, 1'b0, -1);
        // arready stalled 5 cycles, start word 1.
        run_burst(64'h2000_0048, 5, 4'b0000, -1, 3, 8'hC0, 64'h2000_0048,
                  {64'hC2, 64'hC1, 64'hC0, 64'hC3}, 1'b0, 11, 1'b0, -1);
        // rvalid gaps before beats 0 and 2, request dropped after AR.
        run_burst(64'h3000, 0, 4'b0101, -1, 3, 8'hD0, 64'h3000,
                  {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 1'b0, 8, 1'b1, -1);
        // SLVERR on beat 2, start word 2.
        run_burst(64'h4010, 0, 4'b0000, 2, 3, 8'hE0, 64'h4010,
                  {64'hE1, 64'hE0, 64'hE3, 64'hE2}, 1'b1, 6, 1'b0, -1);
        // rlast early on beat 2.
        run_burst(64'h5000, 0, 4'b0000, -1, 2, 8'hF0, 64'h5000,
                  {64'hF3, 64'hF2, 64'hF1, 64'hF0}, 1'b1, 6, 1'b0, -1);
        // Reset after beat 1.
        run_burst(64'h6008, 0, 4'b0000, -1, 3, 8'h90, 64'h6008,
                  256'(0), 1'b0, 0, 1'b0, 1);
        // Fresh request after reset, start word 2.
        last_blk = {64'hB1, 64'hB0, 64'hB3, 64'hB2};
        run_burst(64'h1230, 0, 4'b0000, -1, 3, 8'hB0, 64'h1230,
                  last_blk, 1'b0, 6, 1'b0, -1);
`else
        run_burst(64'h1238, 0, 4'b0000, -1, 3, 8'hA0, 64'h1220,
                  {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 1'b0, 6, 1'b0, -1);
        run_burst(64'h2000_0048, 5, 4'b0000, -1, 3, 8'hC0, 64'h2000_0040,
                  {64'hC3, 64'hC2, 64'hC1, 64'hC0}, 1'b0, 11, 1'b0, -1);
        run_burst(64'h3000, 0, 4'b0101, -1, 3, 8'hD0, 64'h3000,
                  {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 1'b0, 8, 1'b1, -1);
        run_burst(64'h4010, 0, 4'b0000, 2, 3, 8'hE0, 64'h4000,
                  {64'hE3, 64'hE2, 64'hE1, 64'hE0}, 1'b1, 6, 1'b0, -1);
        run_burst(64'h5000, 0, 4'b0000, -1, 2, 8'hF0, 64'h5000,
                  {64'hF3, 64'hF2, 64'hF1, 64'hF0}, 1'b1, 6, 1'b0, -1);
        run_burst(64'h6008, 0, 4'b0000, -1, 3, 8'h90, 64'h6000,
                  256'(0), 1'b0, 0, 1'b0, 1);
        last_blk = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
        run_burst(64'h1230, 0, 4'b0000, -1, 3, 8'hB0, 64'h1220,
                  last_blk, 1'b0, 6, 1'b0, -1);
`endif
        // Line holds after done; no stray burst or done afterwards.
        repeat (5) @(posedge clk);
        #1;
        check("block_hold", block, last_blk);
        check("idle_done", 256'(done), 256'(1'b0));
        check("done_queue_empty", 256'(done_q.size()), 256'(0));
        check("ar_queue_empty", 256'(ar_q.size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
